// File: rtl/dhcp_pkg.sv
// Shared state encoding and wait-time helpers for the DHCP address sequencer.
package dhcp_pkg;

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      LOAD_REQ = 4'd1,
      LOAD_REL = 4'd2,
      DISC_REQ = 4'd3,
      DISC_REL = 4'd4,
      WAIT_ACK = 4'd5,
      BACKOFF  = 4'd6,
      BOUND    = 4'd7,
      FALLBACK = 4'd8
   } state_t;

   localparam int unsigned BACKOFF_CAP_S = 64;

   // Exponential ACK wait: base << retries, computed wide so large shifts cannot wrap below the cap.
   function automatic logic [6:0] wait_secs(input int unsigned base_s, input logic [3:0] retries);
      logic [47:0] secs;
      secs = 48'(base_s) << retries;
      if (secs > 48'(BACKOFF_CAP_S))
         secs = 48'(BACKOFF_CAP_S);
      return secs[6:0];
   endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// One-second prescaler: tick is high for one cycle every TICKS_PER_SEC cycles.
// clear restarts the count so the first tick lands a full second after the clear.
module sec_tick_gen #(
   parameter int unsigned TICKS_PER_SEC = 25000000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int unsigned CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clear)
         cnt <= '0;
      else if (cnt == LAST)
         cnt <= '0;
      else
         cnt <= cnt + CW'(1);
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/dhcp_sequencer.sv
// DHCP address acquisition sequencer: EEPROM load, DISCOVER, ACK wait with exponential
// retry, lease renewal at T1 and static fallback. All outputs are registered.
module dhcp_sequencer import dhcp_pkg::*; #(
   parameter int unsigned TICKS_PER_SEC = 25000000,
   parameter int unsigned TIMEOUT_S     = 4,
   parameter int unsigned MAX_RETRIES   = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   output logic        eeprom_start,
   input  logic        eeprom_finished,
   output logic        discover_start,
   input  logic        discover_finished,
   input  logic        ack_valid,
   input  logic [31:0] ack_lease,
   input  logic        nak_valid,
   output logic        bound,
   output logic        fallback,
   output logic [3:0]  retry_count,
   output logic [3:0]  state_dbg
);

   state_t      state;
   logic        enable_q;
   logic [6:0]  wait_cnt;
   logic [31:0] lease_cnt;
   logic        lease_inf;
   logic        tick;
   logic        tick_clr;
   logic        timeout;
   logic [3:0]  retry_next;
   logic [31:0] lease_t1;

   sec_tick_gen #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_tick (
      .clk   (clk),
      .rst   (rst),
      .clear (tick_clr),
      .tick  (tick)
   );

   assign state_dbg  = state;
   assign timeout    = tick && (wait_cnt <= 7'd1);
   assign retry_next = (retry_count >= 4'(MAX_RETRIES)) ? 4'(MAX_RETRIES) : retry_count + 4'd1;
   assign lease_t1   = (ack_lease < 32'd2) ? 32'd1 : {1'b0, ack_lease[31:1]};

   // Prescaler only runs in timed states; it is held cleared elsewhere and on every counter load.
   always_comb begin
      tick_clr = 1'b1;
      case (state)
         WAIT_ACK:       tick_clr = ack_valid || nak_valid || timeout;
         BACKOFF, BOUND: tick_clr = 1'b0;
         default:        tick_clr = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         enable_q       <= 1'b0;
         eeprom_start   <= 1'b0;
         discover_start <= 1'b0;
         bound          <= 1'b0;
         fallback       <= 1'b0;
         retry_count    <= 4'd0;
         wait_cnt       <= 7'd0;
         lease_cnt      <= 32'd0;
         lease_inf      <= 1'b0;
      end else begin
         enable_q <= enable;
         if (!enable && (state == WAIT_ACK || state == BACKOFF || state == BOUND || state == FALLBACK)) begin
            state       <= IDLE;
            bound       <= 1'b0;
            fallback    <= 1'b0;
            retry_count <= 4'd0;
         end else begin
            case (state)
               IDLE: if (enable && !enable_q) begin
                  state        <= LOAD_REQ;
                  eeprom_start <= 1'b1;
                  retry_count  <= 4'd0;
               end
               LOAD_REQ: if (eeprom_finished) begin
                  state        <= LOAD_REL;
                  eeprom_start <= 1'b0;
               end
               LOAD_REL: if (!eeprom_finished) begin
                  if (enable) begin
                     state          <= DISC_REQ;
                     discover_start <= 1'b1;
                  end else
                     state <= IDLE;
               end
               DISC_REQ: if (discover_finished) begin
                  state          <= DISC_REL;
                  discover_start <= 1'b0;
               end
               DISC_REL: if (!discover_finished) begin
                  if (enable) begin
                     state    <= WAIT_ACK;
                     wait_cnt <= wait_secs(TIMEOUT_S, retry_count);
                  end else begin
                     state       <= IDLE;
                     retry_count <= 4'd0;
                  end
               end
               WAIT_ACK: begin
                  // NAK beats a simultaneous ACK; an ACK landing on the timeout cycle still binds.
                  if (nak_valid || (timeout && !ack_valid)) begin
                     retry_count <= retry_next;
                     if (retry_next == 4'(MAX_RETRIES)) begin
                        state    <= FALLBACK;
                        fallback <= 1'b1;
                     end else
                        state <= BACKOFF;
                  end else if (ack_valid) begin
                     state       <= BOUND;
                     bound       <= 1'b1;
                     retry_count <= 4'd0;
                     lease_cnt   <= lease_t1;
                     lease_inf   <= (ack_lease == 32'hFFFF_FFFF);
                  end else if (tick)
                     wait_cnt <= wait_cnt - 7'd1;
               end
               BACKOFF: if (tick) begin
                  state          <= DISC_REQ;
                  discover_start <= 1'b1;
               end
               BOUND: if (tick && !lease_inf) begin
                  if (lease_cnt <= 32'd1) begin
                     state          <= DISC_REQ;
                     discover_start <= 1'b1;
                     bound          <= 1'b0;
                     retry_count    <= 4'd0;
                  end else
                     lease_cnt <= lease_cnt - 32'd1;
               end
               FALLBACK: state <= FALLBACK;
               default:  state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_dhcp_sequencer.sv
// Directed-plus-random bench for dhcp_sequencer; expected durations come from second/lease arithmetic.
module tb_dhcp_sequencer;
   import dhcp_pkg::*;

   localparam int TPS = 10;
   localparam int TOS = 4;
   localparam int MR  = 4;

   logic        clk = 1'b0;
   logic        rst, enable, eeprom_finished, discover_finished, ack_valid, nak_valid;
   logic [31:0] ack_lease;
   logic        eeprom_start, discover_start, bound, fallback;
   logic [3:0]  retry_count, state_dbg;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dhcp_sequencer #(.TICKS_PER_SEC(TPS), .TIMEOUT_S(TOS), .MAX_RETRIES(MR)) dut (
      .clk               (clk),
      .rst               (rst),
      .enable            (enable),
      .eeprom_start      (eeprom_start),
      .eeprom_finished   (eeprom_finished),
      .discover_start    (discover_start),
      .discover_finished (discover_finished),
      .ack_valid         (ack_valid),
      .ack_lease         (ack_lease),
      .nak_valid         (nak_valid),
      .bound             (bound),
      .fallback          (fallback),
      .retry_count       (retry_count),
      .state_dbg         (state_dbg)
   );

   // Reference: ACK wait in cycles after a given number of failed attempts.
   function automatic int wait_cycles(input int fails);
      longint secs;
      secs = longint'(TOS) * (longint'(1) << fails);
      if (secs > 64) secs = 64;
      return int'(secs) * TPS;
   endfunction

   // Reference: time spent bound before renewal, in cycles (half the lease, at least one second).
   function automatic int lease_cycles(input logic [31:0] lease);
      longint t;
      t = longint'(lease) / 2;
      if (t < 1) t = 1;
      return int'(t) * TPS;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Partner side of a four-phase handshake: finish after d cycles of start, release once start drops.
   task automatic handshake(input bit eep, input int d, input string tag);
      int n;
      n = 0;
      while (((eep ? eeprom_start : discover_start) === 1'b1) && n < 200) begin
         n++;
         if (n == d) begin
            if (eep) eeprom_finished = 1'b1;
            else     discover_finished = 1'b1;
         end
         step();
      end
      chk(tag, n, d);
      eeprom_finished   = 1'b0;
      discover_finished = 1'b0;
      step();
   endtask

   // Counts cycles spent in a state; optionally injects a stray ACK+NAK pulse at one point.
   task automatic count_state(input logic [3:0] st, input int stray_at, output int n);
      n = 0;
      while (state_dbg === st && n < 5000) begin
         if (n == stray_at) begin
            ack_valid = 1'b1;
            nak_valid = 1'b1;
            ack_lease = 32'hFFFF_FFFF;
         end else begin
            ack_valid = 1'b0;
            nak_valid = 1'b0;
         end
         n++;
         step();
      end
      ack_valid = 1'b0;
      nak_valid = 1'b0;
   endtask

   initial begin
      int n, j;
      logic [31:0] lease;

      rst = 1'b1; enable = 1'b0; eeprom_finished = 1'b0; discover_finished = 1'b0;
      ack_valid = 1'b0; nak_valid = 1'b0; ack_lease = 32'd0;
      repeat (3) step();
      chk("rst_eeprom_start", eeprom_start, 0);
      chk("rst_discover_start", discover_start, 0);
      chk("rst_bound", bound, 0);
      chk("rst_fallback", fallback, 0);
      chk("rst_retry", retry_count, 0);
      chk("rst_state", state_dbg, IDLE);

      // Basic sequence with EEPROM taking 5 cycles and DISCOVER 3
      rst = 1'b0;
      step();
      chk("idle_hold", state_dbg, IDLE);
      enable = 1'b1;
      step();
      chk("load_req_state", state_dbg, LOAD_REQ);
      handshake(1'b1, 5, "eeprom_high_cycles");
      chk("discover_rise", discover_start, 1);
      handshake(1'b0, 3, "discover_high_cycles");
      chk("wait_ack_entry", state_dbg, WAIT_ACK);

      j = $urandom_range(0, 30);
      repeat (j) step();
      ack_valid = 1'b1; ack_lease = 32'd20;
      step();
      ack_valid = 1'b0;
      chk("ack_bound", bound, 1);
      chk("ack_retry", retry_count, 0);
      count_state(BOUND, $urandom_range(3, 50), n);
      chk("lease20_cycles", n, lease_cycles(32'd20));
      chk("renew_bound_low", bound, 0);
      chk("renew_discover", discover_start, 1);

      // Random leases, including the sub-2-second corner
      for (int r = 0; r < 3; r++) begin
         handshake(1'b0, $urandom_range(1, 6), "disc_hs_lease");
         lease = (r == 0) ? 32'($urandom_range(0, 1)) : 32'($urandom_range(2, 9));
         repeat ($urandom_range(0, 30)) step();
         ack_valid = 1'b1; ack_lease = lease;
         step();
         ack_valid = 1'b0;
         chk("rand_ack_bound", bound, 1);
         count_state(BOUND, -1, n);
         chk("rand_lease_cycles", n, lease_cycles(lease));
      end

      // No ACK at all: exponential waits, then fallback
      handshake(1'b0, $urandom_range(1, 6), "disc_hs_timeout");
      for (int k = 0; k < MR; k++) begin
         count_state(WAIT_ACK, -1, n);
         chk("timeout_wait_cycles", n, wait_cycles(k));
         chk("retry_after_timeout", retry_count, k + 1);
         if (k < MR - 1) begin
            count_state(BACKOFF, -1, n);
            chk("backoff_cycles", n, TPS);
            handshake(1'b0, $urandom_range(1, 6), "disc_hs_retry");
         end
      end
      chk("fallback_set", fallback, 1);
      chk("fallback_bound", bound, 0);
      chk("fallback_state", state_dbg, FALLBACK);
      repeat ($urandom_range(5, 40)) step();
      chk("fallback_hold", fallback, 1);
      enable = 1'b0;
      step();
      chk("fallback_exit_state", state_dbg, IDLE);
      chk("fallback_exit_flag", fallback, 0);
      chk("fallback_exit_retry", retry_count, 0);

      // Simultaneous ACK and NAK: NAK wins
      enable = 1'b1;
      step();
      handshake(1'b1, $urandom_range(1, 8), "eeprom_hs_nak");
      handshake(1'b0, $urandom_range(1, 8), "disc_hs_nak");
      repeat ($urandom_range(0, 30)) step();
      ack_valid = 1'b1; nak_valid = 1'b1; ack_lease = $urandom;
      step();
      ack_valid = 1'b0; nak_valid = 1'b0;
      chk("nak_wins_state", state_dbg, BACKOFF);
      chk("nak_wins_retry", retry_count, 1);
      chk("nak_wins_bound", bound, 0);
      count_state(BACKOFF, -1, n);
      chk("nak_backoff_cycles", n, TPS);

      // ACK on the exact timeout cycle: ACK wins
      handshake(1'b0, $urandom_range(1, 6), "disc_hs_edge");
      repeat (wait_cycles(1) - 1) step();
      chk("last_wait_cycle", state_dbg, WAIT_ACK);
      lease = 32'($urandom_range(2, 7));
      ack_valid = 1'b1; ack_lease = lease;
      step();
      ack_valid = 1'b0;
      chk("edge_ack_state", state_dbg, BOUND);
      chk("edge_ack_retry", retry_count, 0);
      count_state(BOUND, -1, n);
      chk("edge_lease_cycles", n, lease_cycles(lease));

      // Infinite lease holds, then enable low releases it
      handshake(1'b0, $urandom_range(1, 6), "disc_hs_inf");
      repeat ($urandom_range(0, 30)) step();
      ack_valid = 1'b1; ack_lease = 32'hFFFF_FFFF;
      step();
      ack_valid = 1'b0;
      n = 0;
      for (int c = 0; c < 10000; c++) begin
         nak_valid = (c == 17);
         if (bound === 1'b1) n++;
         step();
      end
      nak_valid = 1'b0;
      chk("infinite_lease_held", n, 10000);
      enable = 1'b0;
      step();
      chk("inf_exit_state", state_dbg, IDLE);
      chk("inf_exit_bound", bound, 0);

      // Enable drops mid-handshake: handshake completes, then IDLE
      enable = 1'b1;
      step();
      chk("restart_load_req", state_dbg, LOAD_REQ);
      enable = 1'b0;
      handshake(1'b1, $urandom_range(1, 8), "eeprom_hs_abort");
      chk("abort_state", state_dbg, IDLE);
      chk("abort_discover", discover_start, 0);

      // Reset during DISC_REQ, then enable held through reset restarts the sequence
      enable = 1'b1;
      step();
      handshake(1'b1, $urandom_range(1, 8), "eeprom_hs_rst");
      chk("pre_rst_discover", discover_start, 1);
      rst = 1'b1;
      step();
      chk("rst_mid_discover", discover_start, 0);
      chk("rst_mid_state", state_dbg, IDLE);
      rst = 1'b0;
      step();
      chk("level_enable_start", eeprom_start, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
